flash_io_sequencer: RTL and testbench
=====================================

// Module: flash_io_sequencer
// PURPOSE
// - Boot-time I/O pattern player for the user-project I/O ring: after reset it reads a byte
//   stream from an external SPI flash (standard READ, 0x03) and presents each byte on an
//   8-bit output port, io_out[7:0], which drives mprj_io[7:0].
// - Each byte is held for a fixed time. Playback stops at the first 0x00 byte or after MAX_BYTES.
// - Sits between the flash pins (flash_csb/clk/io0/io1) and the low user I/O pads.
// PARAMETERS
// - CLK_DIV      2         clock cycles per flash_clk half-period (>=1)
// - BASE_ADDR    24'h0     flash byte address of the first pattern byte
// - HOLD_CYCLES  16        clock cycles each byte stays on io_out before the next fetch (>=1)
// - MAX_BYTES    256       upper bound on bytes played, including the terminator
// PORTS
// - clock      in   1   system clock; all logic on rising edge
// - reset      in   1   asynchronous, active-high reset
// - flash_csb  out  1   flash chip select, active low
// - flash_clk  out  1   flash serial clock, SPI mode 0 (idles low)
// - flash_io0  out  1   flash MOSI: command/address, MSB first
// - flash_io1  in   1   flash MISO: data, MSB first
// - io_out     out  8   current pattern byte
// - io_oeb     out  8   pad output enable, active low
// - byte_stb   out  1   one-cycle pulse when io_out takes a new byte
// - done       out  1   high once playback has terminated; sticky until reset
// BEHAVIOUR
// - Reset values (asynchronous): flash_csb=1, flash_clk=0, flash_io0=0, io_out=8'h00,
//   io_oeb=8'hFF, byte_stb=0, done=0, state=IDLE.
// - IDLE: on the first clock edge after reset deasserts:
//   - drive flash_csb low and io_oeb to 8'h00;
//   - go to CMD.
// - CMD: shift out 8'h03, 8 bits. ADDR: shift out BASE_ADDR, 24 bits. Both MSB first.
// - SPI timing:
//   - flash_io0 changes only while flash_clk is low;
//   - flash_clk toggles every CLK_DIV cycles;
//   - flash_io1 is sampled on the cycle flash_clk rises.
// - DATA: run 8 flash_clk pulses; shift in flash_io1 MSB first.
// - After the 8th rising edge:
//   - load the byte into io_out and pulse byte_stb the next cycle;
//   - flash_clk returns low and pauses; flash_csb stays low;
//   - go to HOLD.
// - HOLD: count HOLD_CYCLES cycles, then:
//   - if the byte shown was 8'h00, or MAX_BYTES bytes have been played -> go to DONE;
//   - otherwise return to DATA. The flash auto-increments the address, so no new
//     command is sent.
// - DONE: flash_csb=1, flash_clk=0, done=1. io_out keeps the last byte and io_oeb stays
//   8'h00. Only reset leaves DONE.
// - flash_clk idles low whenever flash_csb is high.
// - A 0x00 byte is always displayed before termination. 0xFF is an ordinary pattern value.
// - Byte counter width is clog2(MAX_BYTES+1). The counter never wraps; the MAX_BYTES check
//   happens after the byte's HOLD.
// - Reset asserted mid-transfer: all outputs return to reset values in the same instant,
//   flash_csb rises, and after deassert playback restarts from the READ command.
// - flash_io1 is ignored outside DATA.
// TESTING
// - Flash model holding 01..0A,FF,00 at BASE_ADDR -> io_out shows
//   01,02,03,04,05,06,07,08,09,0A,FF,00 in order:
//   - 12 byte_stb pulses;
//   - each value held exactly HOLD_CYCLES + 8*2*CLK_DIV cycles, except the last;
//   - done=1.
// - Command check: the first 32 bits on flash_io0 after flash_csb falls are
//   03,00,00,00 (BASE_ADDR=0). There is exactly one flash_csb low window per playback.
// - Reset during the 5th byte's HOLD -> io_out=00, io_oeb=FF and flash_csb=1 immediately.
//   After release, playback restarts at 01.
// - Flash filled with 8'h55, MAX_BYTES=4 -> exactly 4 byte_stb pulses, io_out=55, done=1,
//   flash_csb=1.
// - First byte 8'h00 -> one byte_stb, io_out=00, done=1 after HOLD_CYCLES.
// - Mode-0 timing: flash_io0 never changes while flash_clk=1, and flash_clk=0 while
//   flash_csb=1, checked for CLK_DIV=1 and CLK_DIV=3.

Source files
------------

// File: rtl/flash_io_sequencer.sv
// flash_io_sequencer: plays a byte stream read from SPI flash (READ 0x03) onto the low user I/O pads
module flash_io_sequencer #(
    parameter int          CLK_DIV     = 2,
    parameter logic [23:0] BASE_ADDR   = 24'h0,
    parameter int          HOLD_CYCLES = 16,
    parameter int          MAX_BYTES   = 256
) (
    input  logic       clock,
    input  logic       reset,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    output logic [7:0] io_out,
    output logic [7:0] io_oeb,
    output logic       byte_stb,
    output logic       done
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [7:0] READ_CMD = 8'h03;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] byte_cnt;
    logic [4:0]    bit_cnt;
    logic [30:0]   sr;
    logic [6:0]    rx;
    logic          shifting, tick, rise, fall;

    // SPI edge strobes and next-state: the byte shown decides between another fetch and stopping
    always_comb begin
        shifting = state inside {CMD, ADDR, DATA};
        tick     = shifting && div_cnt == DW'(CLK_DIV - 1);
        rise     = tick && !flash_clk;
        fall     = tick && flash_clk;
        state_n  = state;
        case (state)
            IDLE:    state_n = CMD;
            CMD:     if (fall && bit_cnt == 5'd7) state_n = ADDR;
            ADDR:    if (fall && bit_cnt == 5'd23) state_n = DATA;
            DATA:    if (fall && bit_cnt == 5'd8) state_n = HOLD;
            HOLD:    if (hold_cnt == HW'(HOLD_CYCLES - 1))
                         state_n = (io_out == 8'h00 || byte_cnt == BW'(MAX_BYTES)) ? DONE : DATA;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // SPI shifter, byte capture and pad outputs; MOSI only moves on the falling flash_clk edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
            io_out    <= 8'h00;
            io_oeb    <= 8'hFF;
            byte_stb  <= 1'b0;
            done      <= 1'b0;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            rx        <= '0;
        end else begin
            flash_csb <= state_n == DONE;
            done      <= state_n == DONE;
            io_oeb    <= 8'h00;
            div_cnt   <= (shifting && !tick) ? div_cnt + 1'b1 : '0;
            flash_clk <= shifting && (tick ? !flash_clk : flash_clk);
            hold_cnt  <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            byte_stb  <= state == DATA && rise && bit_cnt == 5'd7;
            if (state == IDLE) begin
                sr        <= {READ_CMD[6:0], BASE_ADDR};
                flash_io0 <= READ_CMD[7];
            end else if (fall && state != DATA) begin
                sr        <= sr << 1;
                flash_io0 <= sr[30];
            end
            if (state_n != state)
                bit_cnt <= '0;
            else if ((fall && state != DATA) || (rise && state == DATA))
                bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && rise)
                rx <= {rx[5:0], flash_io1};
            if (state == DATA && rise && bit_cnt == 5'd7) begin
                io_out   <= {rx, flash_io1};
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_flash_io_sequencer.sv
// tb_flash_io_sequencer: three parameterisations of the sequencer against a behavioural SPI flash
module tb_flash_io_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst [3];
    logic       csb [3], fclk [3], io0 [3], io1 [3], stb [3], dn [3];
    logic [7:0] iout [3], oeb [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        flash_io_sequencer #(
            .CLK_DIV    (g == 1 ? 1 : (g == 2 ? 3 : 2)),
            .BASE_ADDR  (g == 1 ? 24'h10 : 24'h0),
            .HOLD_CYCLES(g == 1 ? 4 : 16),
            .MAX_BYTES  (g == 1 ? 4 : 256)
        ) u_dut (
            .clock    (clock),
            .reset    (rst[g]),
            .flash_csb(csb[g]),
            .flash_clk(fclk[g]),
            .flash_io0(io0[g]),
            .flash_io1(io1[g]),
            .io_out   (iout[g]),
            .io_oeb   (oeb[g]),
            .byte_stb (stb[g]),
            .done     (dn[g])
        );
    end

    typedef struct {
        int         g;
        int         idx;
        logic [7:0] val;
        int         gap;
    } vec_t;

    logic [7:0]  pat [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    logic [7:0]  mem [3][256];
    logic        pclk [3], pcsb [3], pio0 [3];
    logic [31:0] fcmd [3];
    logic [7:0]  seen [3][16];
    int          scyc [3][16];
    int          fcnt [3], ncs [3], nstb [3], viol [3];
    int          cyc, tests, fails;
    vec_t        vt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: flash model, mode-0 monitor and strobe log, all sampled on the falling clock edge
    task automatic tick();
        int k;
        @(negedge clock);
        cyc++;
        for (int g = 0; g < 3; g++) begin
            if (csb[g] && fclk[g]) viol[g]++;
            if (pclk[g] && fclk[g] && io0[g] !== pio0[g]) viol[g]++;
            if (pcsb[g] && !csb[g]) begin
                fcnt[g] = 0;
                fcmd[g] = '0;
                ncs[g]++;
                io1[g]  = 1'b1;
            end
            if (!csb[g] && !pclk[g] && fclk[g]) begin
                if (fcnt[g] < 32) fcmd[g] = {fcmd[g][30:0], io0[g]};
                fcnt[g]++;
            end
            if (!csb[g] && pclk[g] && !fclk[g] && fcnt[g] >= 32) begin
                k = fcnt[g] - 32;
                io1[g] = mem[g][(int'(fcmd[g][7:0]) + k / 8) % 256][7 - k % 8];
            end
            if (stb[g]) begin
                if (nstb[g] < 16) begin
                    seen[g][nstb[g]] = iout[g];
                    scyc[g][nstb[g]] = cyc;
                end
                nstb[g]++;
            end
            pclk[g] = fclk[g];
            pcsb[g] = csb[g];
            pio0[g] = io0[g];
        end
    endtask

    task automatic restart(input int g);
        rst[g] = 1'b1;
        tick();
        tick();
        nstb[g] = 0;
        ncs[g]  = 0;
        viol[g] = 0;
        rst[g]  = 1'b0;
    endtask

    task automatic wait_done(input int g, input int bound);
        int n = 0;
        while (!dn[g] && n < bound) begin
            tick();
            n++;
        end
        chk($sformatf("done_g%0d", g), {31'b0, dn[g]}, 32'd1);
    endtask

    task automatic wait_stb(input int g, input int cnt, input int bound);
        int n = 0;
        while (nstb[g] < cnt && n < bound) begin
            tick();
            n++;
        end
        chk($sformatf("stb_wait_g%0d", g), {31'b0, nstb[g] >= cnt}, 32'd1);
    endtask

    initial begin
        logic flag;
        tests = 0;
        fails = 0;
        cyc   = 0;
        for (int g = 0; g < 3; g++) begin
            rst[g]  = 1'b1;
            io1[g]  = 1'b1;
            pclk[g] = 1'b0;
            pcsb[g] = 1'b1;
            pio0[g] = 1'b0;
            fcmd[g] = '0;
            fcnt[g] = 0;
            ncs[g]  = 0;
            nstb[g] = 0;
            viol[g] = 0;
            for (int a = 0; a < 256; a++)
                mem[g][a] = (g == 1) ? 8'h55 : (a < 12 ? pat[a] : 8'h00);
        end
        for (int i = 0; i < 12; i++) vt.push_back('{0, i, pat[i], i == 0 ? 0 : 48});
        for (int i = 0; i < 12; i++) vt.push_back('{2, i, pat[i], i == 0 ? 0 : 64});
        for (int i = 0; i < 4; i++)  vt.push_back('{1, i, 8'h55, i == 0 ? 0 : 20});

        repeat (3) tick();
        chk("rst_csb", {31'b0, csb[0]}, 32'd1);
        chk("rst_fclk", {31'b0, fclk[0]}, 32'd0);
        chk("rst_io0", {31'b0, io0[0]}, 32'd0);
        chk("rst_io_out", {24'b0, iout[0]}, 32'h00);
        chk("rst_oeb", {24'b0, oeb[0]}, 32'hFF);
        chk("rst_stb", {31'b0, stb[0]}, 32'd0);
        chk("rst_done", {31'b0, dn[0]}, 32'd0);

        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        tick();
        chk("csb_low_after_rst", {31'b0, csb[0]}, 32'd0);
        chk("oeb_on_after_rst", {24'b0, oeb[0]}, 32'h00);
        for (int g = 0; g < 3; g++) wait_done(g, 5000);

        foreach (vt[i]) begin
            chk($sformatf("byte_g%0d_%0d", vt[i].g, vt[i].idx), {24'b0, seen[vt[i].g][vt[i].idx]}, {24'b0, vt[i].val});
            if (vt[i].gap != 0)
                chk($sformatf("gap_g%0d_%0d", vt[i].g, vt[i].idx),
                    scyc[vt[i].g][vt[i].idx] - scyc[vt[i].g][vt[i].idx - 1], vt[i].gap);
        end
        chk("nstb_g0", nstb[0], 12);
        chk("nstb_g1", nstb[1], 4);
        chk("nstb_g2", nstb[2], 12);
        chk("cmd_g0", fcmd[0], 32'h03000000);
        chk("cmd_g1", fcmd[1], 32'h03000010);
        chk("ncs_g0", ncs[0], 1);
        chk("end_csb_g0", {31'b0, csb[0]}, 32'd1);
        chk("end_fclk_g0", {31'b0, fclk[0]}, 32'd0);
        chk("end_oeb_g0", {24'b0, oeb[0]}, 32'h00);
        chk("end_io_out_g0", {24'b0, iout[0]}, 32'h00);
        chk("end_io_out_g1", {24'b0, iout[1]}, 32'h55);
        chk("end_csb_g1", {31'b0, csb[1]}, 32'd1);
        for (int g = 0; g < 3; g++) chk($sformatf("mode0_g%0d", g), viol[g], 0);

        restart(0);
        wait_stb(0, 5, 2000);
        repeat (5) tick();
        chk("hold5_io_out", {24'b0, iout[0]}, 32'h05);
        #1 rst[0] = 1'b1;
        #1;
        chk("arst_csb", {31'b0, csb[0]}, 32'd1);
        chk("arst_io_out", {24'b0, iout[0]}, 32'h00);
        chk("arst_oeb", {24'b0, oeb[0]}, 32'hFF);
        chk("arst_fclk", {31'b0, fclk[0]}, 32'd0);
        restart(0);
        wait_done(0, 5000);
        chk("rerun_nstb", nstb[0], 12);
        chk("rerun_first", {24'b0, seen[0][0]}, 32'h01);
        chk("rerun_fifth", {24'b0, seen[0][4]}, 32'h05);
        chk("rerun_ncs", ncs[0], 1);
        chk("rerun_mode0", viol[0], 0);

        mem[0][0] = 8'h00;
        restart(0);
        wait_stb(0, 1, 1000);
        flag = 1'b0;
        repeat (15) begin
            tick();
            if (dn[0]) flag = 1'b1;
        end
        chk("zero_done_early", {31'b0, flag}, 32'd0);
        wait_done(0, 100);
        chk("zero_nstb", nstb[0], 1);
        chk("zero_io_out", {24'b0, iout[0]}, 32'h00);
        chk("zero_csb", {31'b0, csb[0]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
